// File: rtl/uart_fifo_bridge_if.sv
// Bus bundle between the CPU side, the UART core and the bridge.
// The bridge takes the slave view; the surrounding logic takes the master view.
interface uart_fifo_bridge_if;
    logic       cpu_wr;
    logic [7:0] cpu_wdata;
    logic       cpu_rd;
    logic [7:0] cpu_rdata;
    logic       rx_avail;
    logic       tx_ready;
    logic       rx_overrun;
    logic       ovr_clr;
    logic       u_valid;
    logic [7:0] u_rx_data;
    logic       u_rd;
    logic       u_busy;
    logic       u_wr;
    logic [7:0] u_tx_data;

    modport slave (
        input  cpu_wr,
        input  cpu_wdata,
        input  cpu_rd,
        input  ovr_clr,
        input  u_valid,
        input  u_rx_data,
        input  u_busy,
        output cpu_rdata,
        output rx_avail,
        output tx_ready,
        output rx_overrun,
        output u_rd,
        output u_wr,
        output u_tx_data
    );

    modport master (
        output cpu_wr,
        output cpu_wdata,
        output cpu_rd,
        output ovr_clr,
        output u_valid,
        output u_rx_data,
        output u_busy,
        input  cpu_rdata,
        input  rx_avail,
        input  tx_ready,
        input  rx_overrun,
        input  u_rd,
        input  u_wr,
        input  u_tx_data
    );
endinterface

// File: rtl/uart_fifo_bridge.sv
// Byte bridge between a CPU register port and a UART core:
// RX and TX circular FIFOs plus a three-state TX strobe sequencer.
module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset,
    uart_fifo_bridge_if.slave   bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_STROBE = 2'd1;
    localparam logic [1:0] T_WAIT   = 2'd2;

    typedef logic [DEPTH_LOG2:0] ptr_t;

    logic [7:0] rx_mem [DEPTH];
    logic [7:0] tx_mem [DEPTH];

    ptr_t rx_wp;
    ptr_t rx_rp;
    ptr_t tx_wp;
    ptr_t tx_rp;

    logic       rx_empty;
    logic       rx_full;
    logic       tx_empty;
    logic       tx_full;
    logic       rx_push;
    logic       rx_pop;
    logic       rx_drop;
    logic       tx_push;
    logic       tx_pop;
    logic       u_rd;
    logic       rx_avail;
    logic       overrun_q;
    logic       u_wr_q;
    logic [7:0] u_tx_data_q;
    logic [1:0] state;

    // Full when pointers share the index bits but differ in the wrap bit.
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[DEPTH_LOG2] != rx_rp[DEPTH_LOG2]) &&
                      (rx_wp[DEPTH_LOG2-1:0] == rx_rp[DEPTH_LOG2-1:0]);
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[DEPTH_LOG2] != tx_rp[DEPTH_LOG2]) &&
                      (tx_wp[DEPTH_LOG2-1:0] == tx_rp[DEPTH_LOG2-1:0]);

    assign u_rd    = bus.u_valid & ~reset;
    assign rx_push = u_rd & ~rx_full;
    assign rx_drop = u_rd & rx_full;
    assign rx_pop  = bus.cpu_rd & ~rx_empty & ~reset;

    assign tx_push = bus.cpu_wr & ~tx_full & ~reset;
    assign tx_pop  = (state == T_IDLE) & ~tx_empty & ~bus.u_busy & ~reset;

    assign rx_avail = ~rx_empty & ~reset;

    assign bus.u_rd       = u_rd;
    assign bus.rx_avail   = rx_avail;
    assign bus.cpu_rdata  = rx_avail ? rx_mem[rx_rp[DEPTH_LOG2-1:0]] : 8'h00;
    assign bus.tx_ready   = reset | ~tx_full;
    assign bus.rx_overrun = overrun_q;
    assign bus.u_wr       = u_wr_q;
    assign bus.u_tx_data  = u_tx_data_q;

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wp[DEPTH_LOG2-1:0]] <= bus.u_rx_data;
        end
        if (tx_push) begin
            tx_mem[tx_wp[DEPTH_LOG2-1:0]] <= bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp <= '0;
            rx_rp <= '0;
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + ptr_t'(1);
            if (rx_pop)  rx_rp <= rx_rp + ptr_t'(1);
            if (tx_push) tx_wp <= tx_wp + ptr_t'(1);
            if (tx_pop)  tx_rp <= tx_rp + ptr_t'(1);
        end
    end

    // A drop wins over a same-cycle clear so no lost byte goes unreported.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (rx_drop) begin
            overrun_q <= 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= T_IDLE;
            u_wr_q      <= 1'b0;
            u_tx_data_q <= 8'h00;
        end else begin
            u_wr_q <= tx_pop;
            if (tx_pop) begin
                u_tx_data_q <= tx_mem[tx_rp[DEPTH_LOG2-1:0]];
            end
            case (state)
                T_IDLE: begin
                    if (tx_pop) state <= T_STROBE;
                end
                T_STROBE: begin
                    state <= T_WAIT;
                end
                T_WAIT: begin
                    if (!bus.u_busy) state <= T_IDLE;
                end
                default: begin
                    state <= T_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge: directed scenarios plus
// randomized CPU/UART traffic against a queue-based reference model.
module tb_uart_fifo_bridge;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_fifo_bridge_if bus ();

    uart_fifo_bridge #(
        .DEPTH_LOG2(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] rxq [$];
    logic [7:0] txq [$];
    bit         ovr_m;
    int         tx_cnt;
    logic [7:0] last_tx;
    bit         mon_en;
    bit         prev_wr;
    int         n_wr;
    int         cyc;
    int         t_prev;
    int         t_last;
    bit         busy_force;
    int         busy_len;
    int         busy_cnt;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // UART core model: busy for busy_len cycles after each write strobe.
    initial begin
        bus.u_busy = 1'b0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.u_wr === 1'b1) busy_cnt = busy_len;
            else if (busy_cnt > 0) busy_cnt--;
            #1 bus.u_busy = busy_force || (busy_cnt > 0);
        end
    end

    // Monitor: pops the TX scoreboard on each strobe and checks RX state.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.u_wr === 1'b1) begin
                    chk("u_wr_single", prev_wr, 0);
                    chk("u_wr_busy", bus.u_busy, 0);
                    if (txq.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL u_wr_unexpected: got pulse data %0h expected none",
                                 bus.u_tx_data);
                    end else begin
                        exp = txq.pop_front();
                        chk("u_tx_data", bus.u_tx_data, exp);
                        last_tx = exp;
                        tx_cnt--;
                    end
                    n_wr++;
                    t_prev = t_last;
                    t_last = cyc;
                end else begin
                    chk("u_tx_hold", bus.u_tx_data, last_tx);
                end
                prev_wr = (bus.u_wr === 1'b1);
                chk("tx_ready", bus.tx_ready, tx_cnt < 16);
                chk("rx_avail", bus.rx_avail, rxq.size() != 0);
                chk("cpu_rdata", bus.cpu_rdata, (rxq.size() != 0) ? rxq[0] : 8'h00);
                chk("rx_overrun", bus.rx_overrun, ovr_m);
            end
        end
    end

    task automatic drive(bit rst, bit vld, logic [7:0] d, bit rd,
                         bit wr, logic [7:0] wd, bit clr);
        bit full;
        bit empty;
        reset         = rst;
        bus.u_valid   = vld;
        bus.u_rx_data = d;
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        bus.cpu_wdata = wd;
        bus.ovr_clr   = clr;
        if (rst) begin
            rxq.delete();
            txq.delete();
            tx_cnt  = 0;
            ovr_m   = 0;
            last_tx = 8'h00;
        end else begin
            full  = (rxq.size() >= 16);
            empty = (rxq.size() == 0);
            if (rd && !empty) void'(rxq.pop_front());
            if (vld && !full) rxq.push_back(d);
            if (vld && full) ovr_m = 1;
            else if (clr) ovr_m = 0;
            if (wr && tx_cnt < 16) begin
                txq.push_back(wd);
                tx_cnt++;
            end
        end
        #1 chk("u_rd", bus.u_rd, vld && !rst);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
    endtask

    initial begin
        int base;
        int cnt;
        bit found;
        bit rst;
        bit vld;
        bit rd;
        bit wr;
        bit clr;
        cyc = 0;
        mon_en = 0;
        prev_wr = 0;
        n_wr = 0;
        t_prev = 0;
        t_last = 0;
        busy_force = 0;
        busy_len = 0;
        tx_cnt = 0;
        ovr_m = 0;
        last_tx = 8'h00;
        reset = 1'b1;
        bus.u_valid = 0;
        bus.u_rx_data = 0;
        bus.cpu_rd = 0;
        bus.cpu_wr = 0;
        bus.cpu_wdata = 0;
        bus.ovr_clr = 0;
        @(negedge clk);
        #1;

        drive(1, 1, 8'h5A, 0, 0, 8'h00, 0);
        mon_en = 1;
        drive(1, 1, 8'h5A, 1, 1, 8'h77, 0);
        chk("rst_rx_avail", bus.rx_avail, 0);
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
        chk("rst_u_wr", bus.u_wr, 0);
        chk("rst_u_tx_data", bus.u_tx_data, 8'h00);
        chk("rst_overrun", bus.rx_overrun, 0);
        chk("rst_u_rd", bus.u_rd, 0);
        idle(2);

        drive(0, 1, 8'hA5, 0, 0, 8'h00, 0);
        chk("rx1_avail", bus.rx_avail, 1);
        chk("rx1_data", bus.cpu_rdata, 8'hA5);
        drive(0, 0, 8'h00, 1, 0, 8'h00, 0);
        chk("rx1_pop_avail", bus.rx_avail, 0);
        chk("rx1_pop_data", bus.cpu_rdata, 8'h00);

        for (int i = 0; i < 17; i++) drive(0, 1, 8'(i), 0, 0, 8'h00, 0);
        chk("ovr_set", bus.rx_overrun, 1);
        for (int i = 0; i < 16; i++) begin
            chk("ovr_read", bus.cpu_rdata, 8'(i));
            drive(0, 0, 8'h00, 1, 0, 8'h00, 0);
        end
        chk("ovr_drained", bus.rx_avail, 0);
        drive(0, 0, 8'h00, 0, 0, 8'h00, 1);
        chk("ovr_clr", bus.rx_overrun, 0);

        for (int i = 0; i < 16; i++) drive(0, 1, 8'(i * 3 + 1), 0, 0, 8'h00, 0);
        drive(0, 1, 8'hEE, 1, 0, 8'h00, 0);
        chk("full_rdwr_ovr", bus.rx_overrun, 1);
        cnt = 0;
        while (bus.rx_avail === 1'b1 && cnt < 40) begin
            drive(0, 0, 8'h00, 1, 0, 8'h00, 0);
            cnt++;
        end
        chk("full_rdwr_count", cnt, 15);
        drive(0, 0, 8'h00, 0, 0, 8'h00, 1);

        busy_len = 10;
        idle(3);
        base = n_wr;
        drive(0, 0, 8'h00, 0, 1, 8'h41, 0);
        drive(0, 0, 8'h00, 0, 1, 8'h42, 0);
        chk("tx_latency", bus.u_wr, 1);
        for (int k = 0; k < 60 && (n_wr - base) < 2; k++) idle(1);
        idle(15);
        chk("tx_two_pulses", n_wr - base, 2);
        chk("tx_spacing", (t_last - t_prev) >= 11, 1);

        busy_len = 0;
        busy_force = 1;
        idle(3);
        for (int i = 0; i < 17; i++) begin
            drive(0, 0, 8'h00, 0, 1, 8'(8'h60 + i), 0);
            if (i == 15) chk("tx_full_ready", bus.tx_ready, 0);
        end
        chk("tx_17th_ignored", bus.tx_ready, 0);
        base = n_wr;
        busy_force = 0;
        for (int k = 0; k < 100 && (n_wr - base) < 16; k++) idle(1);
        idle(10);
        chk("tx_drain16", n_wr - base, 16);
        chk("tx_drain_ready", bus.tx_ready, 1);

        busy_force = 1;
        idle(2);
        for (int i = 0; i < 4; i++) drive(0, 0, 8'h00, 0, 1, 8'(8'hC0 + i), 0);
        busy_force = 0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            idle(1);
            if (bus.u_wr === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk("abort_strobe_seen", found, 1);
        base = n_wr;
        drive(1, 0, 8'h00, 0, 0, 8'h00, 0);
        chk("abort_u_wr", bus.u_wr, 0);
        chk("abort_tx_ready", bus.tx_ready, 1);
        idle(30);
        chk("abort_no_more_wr", n_wr - base, 0);

        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) busy_len = $urandom_range(0, 4);
            rst = ($urandom_range(0, 299) == 0);
            vld = ($urandom_range(0, 99) < 45);
            rd  = ($urandom_range(0, 99) < 40);
            wr  = ($urandom_range(0, 99) < 30);
            clr = ($urandom_range(0, 99) < 5);
            drive(rst, vld, 8'($urandom), rd, wr, 8'($urandom), clr);
        end
        for (int k = 0; k < 300 && txq.size() != 0; k++) idle(1);
        idle(5);
        chk("final_tx_drained", txq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_fifo_bridge.md
UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving a FIFO depth of 2^DEPTH_LOG2 bytes for each of the RX and TX FIFOs.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port cpu_wr, input, 1 bit: push cpu_wdata into the TX FIFO.
REQ-005 SHALL have port cpu_wdata, input, 8 bits: byte to transmit.
REQ-006 SHALL have port cpu_rd, input, 1 bit: pop the head of the RX FIFO.
REQ-007 SHALL have port cpu_rdata, output, 8 bits: head of the RX FIFO (fall-through).
REQ-008 SHALL have port rx_avail, output, 1 bit: RX FIFO not empty.
REQ-009 SHALL have port tx_ready, output, 1 bit: TX FIFO not full.
REQ-010 SHALL have port rx_overrun, output, 1 bit: sticky flag, set when a received byte is dropped.
REQ-011 SHALL have port ovr_clr, input, 1 bit: clears rx_overrun.
REQ-012 SHALL have port u_valid, input, 1 bit: UART core holds a received byte.
REQ-013 SHALL have port u_rx_data, input, 8 bits: UART core received byte.
REQ-014 SHALL have port u_rd, output, 1 bit: read strobe to the UART core.
REQ-015 SHALL have port u_busy, input, 1 bit: UART core transmitter is active.
REQ-016 SHALL have port u_wr, output, 1 bit: write strobe to the UART core.
REQ-017 SHALL have port u_tx_data, output, 8 bits: byte presented to the UART core.

Function
REQ-018 FIFOs SHALL be circular with (DEPTH_LOG2+1)-bit read/write pointers; empty when the pointers are equal, full when they differ only in the MSB; pointers wrap modulo 2^(DEPTH_LOG2+1).
REQ-019 u_rd SHALL equal u_valid AND NOT reset (combinational), so one UART byte is consumed per valid assertion and the core releases valid on the following cycle.
REQ-020 On a cycle with u_rd=1, u_rx_data SHALL be pushed when the RX FIFO is not full, else dropped and rx_overrun set; the full flag is the pre-edge value, so a simultaneous cpu_rd does not make room.
REQ-021 If ovr_clr and a drop occur in the same cycle, rx_overrun SHALL end set.
REQ-022 cpu_rd when the FIFO is empty SHALL be ignored; cpu_rd with a simultaneous push to a non-empty, non-full FIFO SHALL perform both.
REQ-023 cpu_rdata SHALL equal the head entry when rx_avail=1, and 8'h00 when the FIFO is empty.
REQ-024 cpu_wr when the TX FIFO is full SHALL be ignored without a flag; cpu_wr with a simultaneous internal pop SHALL perform both.
REQ-025 The TX FSM SHALL have states T_IDLE, T_STROBE and T_WAIT.
REQ-026 T_IDLE -> T_STROBE when the TX FIFO is not empty and u_busy=0: register u_tx_data from the head entry, pop it, and set u_wr=1.
REQ-027 T_STROBE SHALL last exactly one cycle, with u_wr=1 and u_tx_data stable, then go to T_WAIT with u_wr=0.
REQ-028 T_WAIT -> T_IDLE on the first cycle with u_busy=0.
REQ-029 Timing SHALL be as follows: u_wr asserts 1 cycle after the FIFO becomes non-empty while idle; the minimum spacing between u_wr pulses is 3 cycles plus the u_busy-high time.
REQ-030 u_tx_data SHALL hold its last value outside T_STROBE.

Reset
REQ-031 While reset=1, on each edge: pointers SHALL be zeroed, both FIFOs empty, TX FSM in T_IDLE, u_wr=0, u_tx_data=8'h00 and rx_overrun=0; FIFO memory contents are not reset.
REQ-032 While reset=1, outputs SHALL be: u_rd=0, rx_avail=0, tx_ready=1, cpu_rdata=8'h00.
REQ-033 Reset asserted mid-T_STROBE or mid-T_WAIT SHALL abort to T_IDLE; any queued TX bytes SHALL be discarded.

Verification
REQ-034 Reset, then u_valid=1 with u_rx_data=8'hA5 for one cycle -> u_rd=1 that cycle; next cycle rx_avail=1 and cpu_rdata=8'hA5; cpu_rd -> rx_avail=0 and cpu_rdata=8'h00.
REQ-035 Push 17 bytes 8'h00..8'h10 via UART with no cpu_rd (DEPTH_LOG2=4) -> 16 stored and rx_overrun=1; reads return 8'h00..8'h0F in order; ovr_clr -> rx_overrun=0.
REQ-036 cpu_wr 8'h41, 8'h42 back-to-back, model holding u_busy high for 10 cycles after each u_wr -> exactly two single-cycle u_wr pulses carrying 8'h41 then 8'h42, the second no earlier than the first cycle after u_busy falls.
REQ-037 Fill the TX FIFO with u_busy held at 1 -> tx_ready=0 after 16 writes and a 17th write is ignored; release u_busy -> 16 bytes emitted in order.
REQ-038 Assert reset during T_STROBE with 3 bytes queued -> next cycle u_wr=0, tx_ready=1, and no further u_wr after reset deasserts.
REQ-039 With the RX FIFO full, cpu_rd and u_valid in the same cycle -> byte dropped, rx_overrun=1, FIFO count 15.
